// File: rtl/remote_cmd_sequencer.sv
// rtl/remote_cmd_sequencer.sv - queued RemoteComm command sequencer with retry/timeout (option: QCS_EMER_BYPASS_EN)
module remote_cmd_sequencer #(
    parameter int          DEPTH       = 8,
    parameter int          DATA_W      = 16,
    parameter int          TIMEOUT_CYC = 1_000_000,
    parameter int          MAX_RETRY   = 2,
    parameter logic [7:0]  ACK_VAL     = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_cmd,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic              ovfl,
    input  logic              flush,
    output logic [7:0]        cmd,
    output logic [DATA_W-1:0] data,
    output logic              send_cmd,
    input  logic              resp_rdy,
    input  logic [7:0]        resp,
    output logic              clr_resp_rdy,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        err_cmd
`ifdef QCS_EMER_BYPASS_EN
    ,
    input  logic              emer_req
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, ACKR} state_t;

    state_t            state;
    logic [7:0]        mem_cmd  [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nxt;
    logic [TW-1:0]     tcnt;
    logic [RW-1:0]     rcnt;
    logic [7:0]        resp_q;
    logic              emer_active;

    logic fifo_flush;
    logic push;
    logic pop;
    logic timeout_hit;
    logic try_fail;
    logic emer_go;

    // FIFO handshake and failed-try qualification
    always_comb begin
`ifdef QCS_EMER_BYPASS_EN
        fifo_flush = flush | emer_req;
`else
        fifo_flush = flush;
`endif
        push        = wr_en && !full && !fifo_flush;
        timeout_hit = (state == WAIT) && !resp_rdy && (tcnt == TW'(TIMEOUT_CYC - 1));
        try_fail    = timeout_hit || ((state == ACKR) && (resp_q != ACK_VAL));
`ifdef QCS_EMER_BYPASS_EN
        // Emergency takes over when idle, or when the current try finishes
        emer_go = emer_req && !emer_active &&
                  ((state == IDLE) || timeout_hit || (state == ACKR));
`else
        emer_go = 1'b0;
`endif
        pop       = (state == IDLE) && !empty && !flush && !emer_go;
        count_nxt = count + CW'(push) - CW'(pop);
    end

    // Entry storage; no reset needed since occupancy is tracked separately
    always_ff @(posedge clk) begin
        if (push) begin
            mem_cmd[wr_ptr]  <= wr_cmd;
            mem_data[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and registered full/empty/overflow flags
    always_ff @(posedge clk) begin
        if (rst || fifo_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
        if (rst) ovfl <= 1'b0;
        else     ovfl <= wr_en && full && !fifo_flush;
    end

    assign busy = (state != IDLE);

    // Command sequencing: issue, wait for response or timeout, retry or report
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cmd          <= '0;
            data         <= '0;
            send_cmd     <= 1'b0;
            clr_resp_rdy <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            err_cmd      <= '0;
            tcnt         <= '0;
            rcnt         <= '0;
            resp_q       <= '0;
            emer_active  <= 1'b0;
        end else if (flush) begin
            state        <= IDLE;
            send_cmd     <= 1'b0;
            clr_resp_rdy <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            tcnt         <= '0;
            rcnt         <= '0;
            emer_active  <= 1'b0;
        end else begin
            send_cmd     <= 1'b0;
            clr_resp_rdy <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            if (emer_go) begin
                cmd         <= 8'h07;
                data        <= '0;
                emer_active <= 1'b1;
                rcnt        <= '0;
                state       <= LOAD;
            end else begin
                case (state)
                    IDLE: begin
                        rcnt <= '0;
                        // A response arriving after a flush still has to be acknowledged
                        clr_resp_rdy <= resp_rdy && !clr_resp_rdy;
                        if (pop) begin
                            cmd   <= mem_cmd[rd_ptr];
                            data  <= mem_data[rd_ptr];
                            state <= LOAD;
                        end
                    end
                    LOAD: begin
                        send_cmd <= 1'b1;
                        state    <= SEND;
                    end
                    SEND: begin
                        tcnt  <= '0;
                        state <= WAIT;
                    end
                    WAIT: begin
                        tcnt <= tcnt + TW'(1);
                        if (resp_rdy) begin
                            resp_q       <= resp;
                            clr_resp_rdy <= 1'b1;
                            state        <= ACKR;
                        end
                    end
                    ACKR: begin
                        if (resp_q == ACK_VAL) begin
                            done        <= 1'b1;
                            emer_active <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
                if (try_fail) begin
                    if (emer_active || (rcnt < RW'(MAX_RETRY))) begin
                        rcnt  <= rcnt + RW'(1);
                        state <= LOAD;
                    end else begin
                        err     <= 1'b1;
                        err_cmd <= cmd;
                        state   <= IDLE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_remote_cmd_sequencer.sv
// tb/tb_remote_cmd_sequencer.sv - self-checking bench for remote_cmd_sequencer
module tb_remote_cmd_sequencer;

    localparam int DEPTH   = 8;
    localparam int DATA_W  = 16;
    localparam int TMO     = 100;
    localparam int MAXR    = 2;
    localparam logic [7:0] ACK = 8'hA5;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [7:0]        wr_cmd;
    logic [DATA_W-1:0] wr_data;
    logic              full, empty, ovfl, flush;
    logic [7:0]        cmd;
    logic [DATA_W-1:0] data;
    logic              send_cmd;
    logic              resp_rdy;
    logic [7:0]        resp;
    logic              clr_resp_rdy, busy, done, err;
    logic [7:0]        err_cmd;

    remote_cmd_sequencer #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .TIMEOUT_CYC(TMO), .MAX_RETRY(MAXR), .ACK_VAL(ACK)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_cmd(wr_cmd), .wr_data(wr_data),
        .full(full), .empty(empty), .ovfl(ovfl), .flush(flush),
        .cmd(cmd), .data(data), .send_cmd(send_cmd),
        .resp_rdy(resp_rdy), .resp(resp), .clr_resp_rdy(clr_resp_rdy),
        .busy(busy), .done(done), .err(err), .err_cmd(err_cmd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Response plan per try: -1 = never respond, else (delay << 8) | byte
    int          plan[$];
    logic [7:0]  sent_cmd[$];
    logic [15:0] sent_data[$];
    int          sent_cyc[$];
    int done_cnt = 0, err_cnt = 0, ovfl_cnt = 0, clr_cnt = 0;
    int stray_req = 0, stray_seen = 0;
    bit pend = 0;
    int pdly = 0;
    logic [7:0] pbyte = '0;

    // Behavioural RemoteComm responder and pulse counters
    always @(negedge clk) begin
        int p;
        done_cnt += int'(done);
        err_cnt  += int'(err);
        ovfl_cnt += int'(ovfl);
        clr_cnt  += int'(clr_resp_rdy);
        if (rst) begin
            resp_rdy = 1'b0;
            pend     = 0;
        end else begin
            if (clr_resp_rdy) resp_rdy = 1'b0;
            if (flush) pend = 0;
            if (send_cmd) begin
                sent_cmd.push_back(cmd);
                sent_data.push_back(data);
                sent_cyc.push_back(cyc);
                if (plan.size() > 0) p = plan.pop_front();
                else                 p = (5 << 8) | 32'(ACK);
                if (p < 0) pend = 0;
                else begin
                    pend  = 1;
                    pdly  = p >> 8;
                    pbyte = p[7:0];
                end
            end else if (pend) begin
                if (pdly <= 1) begin
                    resp_rdy = 1'b1;
                    resp     = pbyte;
                    pend     = 0;
                end else pdly--;
            end
            if (stray_req != stray_seen) begin
                stray_seen = stray_req;
                resp_rdy   = 1'b1;
                resp       = 8'h5A;
            end
        end
    end

    int total = 0, passed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic [7:0] c, input logic [15:0] d);
        wr_en = 1'b1; wr_cmd = c; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0, quiet = 0;
        while (quiet < 3 && n < budget) begin
            @(negedge clk);
            n++;
            if (!busy && empty && !resp_rdy && !pend) quiet++;
            else quiet = 0;
        end
        chk(tag, 32'(n < budget), 32'd1);
    endtask

    logic [7:0]  exp_cmd[$];
    logic [15:0] exp_data[$];
    logic [7:0]  exp_err_cmd;
    int base, d0, e0, o0, c0, bad, lat, exp_done, exp_err;
    logic [7:0]  rc;
    logic [15:0] rd;
    int k, nb;
    bit acked;

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_cmd = '0; wr_data = '0; flush = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_outs", {send_cmd, clr_resp_rdy, done, err, ovfl}, 32'd0);
        chk("rst_cmd_data", {cmd, data, err_cmd}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Two commands, each ACKed after 50 cycles
        base = sent_cmd.size(); d0 = done_cnt; e0 = err_cnt;
        plan.push_back((50 << 8) | 32'(ACK));
        plan.push_back((50 << 8) | 32'(ACK));
        push(8'h06, 16'h0000);
        push(8'h05, 16'h00FF);
        wait_idle("t1_idle", 2000);
        chk("t1_nsent", sent_cmd.size() - base, 2);
        chk("t1_first", {sent_cmd[base], sent_data[base]}, 32'h06_0000);
        chk("t1_second", {sent_cmd[base+1], sent_data[base+1]}, 32'h05_00FF);
        chk("t1_done", done_cnt - d0, 2);
        chk("t1_err", err_cnt - e0, 0);
        chk("t1_empty", 32'(empty), 32'd1);

        // Push to send_cmd latency
        wr_en = 1'b1; wr_cmd = 8'h03; wr_data = 16'hABCD;
        lat = 0;
        do begin
            @(negedge clk);
            wr_en = 1'b0;
            lat++;
        end while (!send_cmd && lat < 10);
        chk("latency", lat, 3);
        wait_idle("lat_idle", 2000);

        // NAK twice then ACK: three identical tries
        base = sent_cmd.size(); d0 = done_cnt; e0 = err_cnt;
        plan.push_back((3 << 8) | 32'hEE);
        plan.push_back((3 << 8) | 32'hEE);
        plan.push_back((3 << 8) | 32'(ACK));
        push(8'h05, 16'h00FF);
        wait_idle("t2_idle", 2000);
        chk("t2_nsent", sent_cmd.size() - base, 3);
        bad = 0;
        for (int i = base; i < sent_cmd.size(); i++)
            if ({sent_cmd[i], sent_data[i]} !== 24'h05_00FF) bad++;
        chk("t2_same", bad, 0);
        chk("t2_done", done_cnt - d0, 1);
        chk("t2_err", err_cnt - e0, 0);

        // No response at all: three tries spaced by the timeout, then err
        base = sent_cmd.size(); d0 = done_cnt; e0 = err_cnt;
        repeat (MAXR + 1) plan.push_back(-1);
        push(8'h02, 16'h1234);
        wait_idle("t3_idle", 2000);
        chk("t3_nsent", sent_cmd.size() - base, MAXR + 1);
        chk("t3_gap1", sent_cyc[base+1] - sent_cyc[base], TMO + 2);
        chk("t3_gap2", sent_cyc[base+2] - sent_cyc[base+1], TMO + 2);
        chk("t3_err", err_cnt - e0, 1);
        chk("t3_done", done_cnt - d0, 0);
        exp_err_cmd = 8'h02;
        chk("t3_err_cmd", 32'(err_cmd), 32'(exp_err_cmd));
        chk("t3_busy", 32'(busy), 32'd0);

        // Overflow while the first command waits
        base = sent_cmd.size(); d0 = done_cnt; o0 = ovfl_cnt;
        exp_cmd.delete(); exp_data.delete();
        plan.push_back((60 << 8) | 32'(ACK));
        exp_cmd.push_back(8'h08); exp_data.push_back(16'h0001);
        push(8'h08, 16'h0001);
        repeat (6) @(negedge clk);
        for (int i = 0; i <= DEPTH; i++) begin
            rc = 8'(2 + $urandom_range(0, 6));
            rd = 16'($urandom);
            if (i < DEPTH) begin
                exp_cmd.push_back(rc);
                exp_data.push_back(rd);
            end
            push(rc, rd);
        end
        chk("t4_full", 32'(full), 32'd1);
        repeat (2) @(negedge clk);
        chk("t4_ovfl", ovfl_cnt - o0, 1);
        wait_idle("t4_idle", 5000);
        chk("t4_nsent", sent_cmd.size() - base, DEPTH + 1);
        bad = 0;
        for (int i = 0; i < exp_cmd.size() && base + i < sent_cmd.size(); i++)
            if (sent_cmd[base+i] !== exp_cmd[i] || sent_data[base+i] !== exp_data[i]) bad++;
        chk("t4_order", bad, 0);
        chk("t4_done", done_cnt - d0, DEPTH + 1);

        // Flush during WAIT with 3 queued, then a stray response
        base = sent_cmd.size(); d0 = done_cnt; e0 = err_cnt;
        plan.push_back((80 << 8) | 32'(ACK));
        for (int i = 0; i < 4; i++) push(8'(2 + i), 16'(i));
        repeat (4) @(negedge clk);
        chk("t5_busy_pre", 32'(busy), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        chk("t5_empty", 32'(empty), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        c0 = clr_cnt;
        stray_req++;
        repeat (6) @(negedge clk);
        chk("t5_clr", clr_cnt - c0, 1);
        chk("t5_resp_rdy", 32'(resp_rdy), 32'd0);
        chk("t5_nsent", sent_cmd.size() - base, 1);
        chk("t5_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);

        // Randomized commands and outcomes against the reference model
        base = sent_cmd.size(); d0 = done_cnt; e0 = err_cnt;
        exp_cmd.delete(); exp_data.delete();
        exp_done = 0; exp_err = 0;
        for (int r = 0; r < 6; r++) begin
            rc = 8'(2 + $urandom_range(0, 6));
            rd = 16'($urandom);
            acked = 0;
            for (int t = 0; t <= MAXR && !acked; t++) begin
                exp_cmd.push_back(rc);
                exp_data.push_back(rd);
                k = $urandom_range(0, 3);
                if (k <= 1) begin
                    acked = 1;
                    plan.push_back(($urandom_range(1, 30) << 8) | 32'(ACK));
                end else if (k == 2) begin
                    nb = $urandom_range(0, 255);
                    if (nb == 32'(ACK)) nb = 0;
                    plan.push_back(($urandom_range(1, 30) << 8) | nb);
                end else plan.push_back(-1);
            end
            if (acked) exp_done++;
            else begin
                exp_err++;
                exp_err_cmd = rc;
            end
            push(rc, rd);
        end
        wait_idle("t6_idle", 20000);
        chk("t6_nsent", sent_cmd.size() - base, exp_cmd.size());
        bad = 0;
        for (int i = 0; i < exp_cmd.size() && base + i < sent_cmd.size(); i++)
            if (sent_cmd[base+i] !== exp_cmd[i] || sent_data[base+i] !== exp_data[i]) bad++;
        chk("t6_seq", bad, 0);
        chk("t6_done", done_cnt - d0, exp_done);
        chk("t6_err", err_cnt - e0, exp_err);
        chk("t6_err_cmd", 32'(err_cmd), 32'(exp_err_cmd));

        // Reset clears the held error opcode
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst2_err_cmd", 32'(err_cmd), 32'd0);
        chk("rst2_empty", 32'(empty), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
